// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed seven-segment scanner with frame-aligned display updates
module seg7_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [11:0] leds,
    output logic        frame_done,
    output logic        pending
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [15:0]      disp;
    logic [15:0]      pend;
    logic             pend_v;
    logic             tick;
    logic             fb;
    logic [3:0]       nib;
    logic [3:0]       nz;
    logic             blank;
    logic [6:0]       glyph;
    logic [3:0]       an_next;
    logic [7:0]       seg_next;

    assign tick    = (div == DIV_LAST);
    assign fb      = tick && (idx == 2'd3);
    assign pending = pend_v;
    assign leds    = {an, seg};

    // Divider: sets how many clk cycles each digit is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Digit index advances on every divider tick and wraps after digit 3
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end
    end

    // Writes park in pend; disp only changes at a frame boundary so a frame never mixes values.
    // A write landing on the boundary itself waits for the following boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp   <= 16'h0000;
            pend   <= 16'h0000;
            pend_v <= 1'b0;
        end else begin
            if (fb && pend_v) begin
                disp <= pend;
            end
            if (wr_en) begin
                pend   <= wr_data;
                pend_v <= 1'b1;
            end else if (fb) begin
                pend_v <= 1'b0;
            end
        end
    end

    // Select the current digit and decide whether it is a blanked leading zero
    always_comb begin
        nz[0] = |disp[3:0];
        nz[1] = |disp[7:4];
        nz[2] = |disp[11:8];
        nz[3] = |disp[15:12];
        nib   = 4'h0;
        blank = 1'b0;
        case (idx)
            2'd0: begin nib = disp[3:0];   blank = 1'b0; end
            2'd1: begin nib = disp[7:4];   blank = blank_lz && !(nz[1] || nz[2] || nz[3]); end
            2'd2: begin nib = disp[11:8];  blank = blank_lz && !(nz[2] || nz[3]); end
            default: begin nib = disp[15:12]; blank = blank_lz && !nz[3]; end
        endcase
    end

    // Active-low hex glyphs, segment order {g,f,e,d,c,b,a}
    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    end

    // Next anode/segment pattern; a blanked digit drives nothing, including its decimal point
    always_comb begin
        an_next  = 4'hF;
        seg_next = 8'hFF;
        if (!blank) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = {~dp_mask[idx], glyph};
        end
    end

    // Registered outputs so the board pins are glitch-free; frame_done marks the boundary cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= 4'hF;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            frame_done <= fb;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [11:0] leds;
    logic        frame_done;
    logic        pending;

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pend_v;
    logic [7:0]  dec_tab [16];

    seg7_scan_driver #(.SCAN_DIV(S)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .blank_lz(blank_lz),
        .dp_mask(dp_mask),
        .an(an),
        .seg(seg),
        .leds(leds),
        .frame_done(frame_done),
        .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] exp_digit(input int d);
        logic [3:0] nib;
        logic       blank;
        nib   = m_disp[d*4 +: 4];
        blank = 1'b0;
        if (blank_lz && d > 0) begin
            blank = 1'b1;
            for (int k = d; k < 4; k++)
                if (m_disp[k*4 +: 4] != 4'h0) blank = 1'b0;
        end
        if (blank) return 12'hFFF;
        return {~(4'b0001 << d), ~dp_mask[d], dec_tab[nib][6:0]};
    endfunction

    task automatic model_reset();
        m_disp   = 16'h0000;
        m_pend   = 16'h0000;
        m_pend_v = 1'b0;
        exp_q.delete();
    endtask

    // Checks one full frame of 16 samples; writes are driven at samples wa1/wa2 (0 = none)
    task automatic check_frame(input bit sync, input int wa1, input logic [15:0] wd1,
                               input int wa2, input logic [15:0] wd2);
        int          n;
        logic [11:0] e;
        bit          wr_prev;
        logic [15:0] wd_prev;
        if (sync) begin
            n = 0;
            while (frame_done !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (frame_done !== 1'b1) begin
                failures++;
                $display("FAIL frame_sync: frame_done=%b required 1", frame_done);
            end
        end
        for (int d = 0; d < 4; d++) exp_q.push_back(exp_digit(d));
        wr_prev = 1'b0;
        wd_prev = 16'h0000;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 16) begin
                if (m_pend_v) m_disp = m_pend;
                if (!wr_prev) m_pend_v = 1'b0;
            end
            if (wr_prev) begin
                m_pend   = wd_prev;
                m_pend_v = 1'b1;
            end
            e = (exp_q.size() > 0) ? exp_q[0] : 12'hxxx;
            checks++;
            if ({an, seg} !== e) begin
                failures++;
                $display("FAIL an_seg sample %0d: got an=%b seg=%h required an=%b seg=%h",
                         j, an, seg, e[11:8], e[7:0]);
            end
            checks++;
            if (leds !== e) begin
                failures++;
                $display("FAIL leds sample %0d: got %h required %h", j, leds, e);
            end
            checks++;
            if (frame_done !== 1'(j == 16)) begin
                failures++;
                $display("FAIL frame_done sample %0d: got %b required %b", j, frame_done, j == 16);
            end
            checks++;
            if (pending !== m_pend_v) begin
                failures++;
                $display("FAIL pending sample %0d: got %b required %b", j, pending, m_pend_v);
            end
            if (j % 4 == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
            if (j == wa1) begin
                wr_en = 1'b1; wr_data = wd1; wr_prev = 1'b1; wd_prev = wd1;
            end else if (j == wa2) begin
                wr_en = 1'b1; wr_data = wd2; wr_prev = 1'b1; wd_prev = wd2;
            end else begin
                wr_en = 1'b0; wr_prev = 1'b0;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (leds !== 12'hFFF || an !== 4'hF || seg !== 8'hFF) begin
            failures++;
            $display("FAIL reset_outputs: got an=%h seg=%h leds=%h required F FF FFF", an, seg, leds);
        end
        checks++;
        if (frame_done !== 1'b0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got frame_done=%b pending=%b required 0 0", frame_done, pending);
        end
        model_reset();
        reset = 1'b0;
        check_frame(1'b0, 0, 16'h0, 0, 16'h0);
        check_frame(1'b1, 0, 16'h0, 0, 16'h0);
    endtask

    task automatic test_write_latency();
        check_frame(1'b1, 5, 16'h12AF, 0, 16'h0);
        check_frame(1'b1, 0, 16'h0, 0, 16'h0);
    endtask

    task automatic test_overwrite();
        check_frame(1'b1, 2, 16'h1111, 6, 16'h2222);
        check_frame(1'b1, 0, 16'h0, 0, 16'h0);
    endtask

    task automatic test_back_to_back();
        check_frame(1'b1, 4, 16'h3333, 15, 16'h4444);
        check_frame(1'b1, 0, 16'h0, 0, 16'h0);
        check_frame(1'b1, 0, 16'h0, 0, 16'h0);
    endtask

    task automatic test_blank_dp();
        blank_lz = 1'b1;
        dp_mask  = 4'b0001;
        check_frame(1'b1, 3, 16'h0050, 0, 16'h0);
        check_frame(1'b1, 7, 16'h0000, 0, 16'h0);
        dp_mask = 4'b0000;
        check_frame(1'b1, 0, 16'h0, 0, 16'h0);
        blank_lz = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            wr_en   = (j == 3);
            wr_data = 16'h5A5A;
        end
        checks++;
        if (an !== 4'b1011 || pending !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state: got an=%b pending=%b required 1011 1", an, pending);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || leds !== 12'hFFF) begin
            failures++;
            $display("FAIL async_reset_outputs: got an=%h seg=%h leds=%h required F FF FFF", an, seg, leds);
        end
        checks++;
        if (pending !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_flags: got pending=%b frame_done=%b required 0 0", pending, frame_done);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_frame(1'b0, 0, 16'h0, 0, 16'h0);
        check_frame(1'b1, 0, 16'h0, 0, 16'h0);
    endtask

    initial begin
        dec_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        model_reset();
        test_reset();
        test_write_latency();
        test_overwrite();
        test_back_to_back();
        test_blank_dp();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
